xrv1_branch_sched: RTL and testbench



---
 rtl/xrv1_branch_sched_pkg.sv | 17 +
 rtl/xrv1_rr_arb.sv | 52 +++++
 rtl/xrv1_branch_sched.sv | 137 +++++++++++++
 tb/tb_xrv1_branch_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrv1_branch_sched_pkg.sv
// Shared types and constants for the branch scheduler.
package xrv1_branch_sched_pkg;

  localparam int REDIR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REDIR = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [REDIR_CNT_W-1:0] sat_inc(input logic [REDIR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/xrv1_rr_arb.sv
// Round-robin arbiter: searches upward from an internal pointer, wrapping at
// the top, and moves the pointer one past the winner on every grant.
module xrv1_rr_arb
  import xrv1_branch_sched_pkg::*;
#(
  parameter int NUM_REQ_P = 4,
  parameter int IDX_W_P   = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ_P-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_REQ_P-1:0] gnt_o,
  output logic [IDX_W_P-1:0]   gnt_idx_o
);

  logic [IDX_W_P-1:0] ptr_q;
  logic [IDX_W_P:0]   sum;
  logic [IDX_W_P-1:0] idx;
  logic               found;

  // First asserted request at or above ptr, wrapping; masked by en_i.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W_P+1)'(i);
      if (sum >= (IDX_W_P+1)'(NUM_REQ_P)) begin
        sum = sum - (IDX_W_P+1)'(NUM_REQ_P);
      end
      idx = sum[IDX_W_P-1:0];
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

  // Pointer advances past the winner; with one requester it stays at 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (gnt_idx_o == IDX_W_P'(NUM_REQ_P-1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/xrv1_branch_sched.sv
// Branch scheduler: arbitrates branch/jump ops from several hardware threads
// into a single branch unit and forwards branch-unit redirects to fetch.
//
//   state | meaning
//   IDLE  | issue register empty, may grant
//   ISSUE | op presented to branch unit (b_req_o=1), may grant back-to-back
//   REDIR | redirect held for fetch, no grants
module xrv1_branch_sched
  import xrv1_branch_sched_pkg::*;
#(
  parameter int NUM_THREADS_P = 4,
  parameter int ITAG_WIDTH_P  = 6,
  parameter int TID_WIDTH_P   = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_THREADS_P-1:0]                 req_vld_i,
  output logic [NUM_THREADS_P-1:0]                 req_rdy_o,
  input  logic [NUM_THREADS_P-1:0]                 req_is_branch_i,
  input  logic [NUM_THREADS_P-1:0]                 req_is_jump_i,
  input  logic [NUM_THREADS_P-1:0][31:0]           req_next_pc_i,
  input  logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0] req_itag_i,
  output logic                                     b_req_o,
  output logic                                     b_is_branch_o,
  output logic                                     b_is_jump_o,
  output logic [31:0]                              b_next_pc_o,
  output logic [ITAG_WIDTH_P-1:0]                  b_itag_o,
  output logic [TID_WIDTH_P-1:0]                   b_tid_o,
  input  logic                                     b_rdy_i,
  input  logic                                     exec_b_pc_vld_i,
  input  logic [31:0]                              exec_b_pc_i,
  output logic                                     redir_vld_o,
  input  logic                                     redir_rdy_i,
  output logic [31:0]                              redir_pc_o,
  output logic [TID_WIDTH_P-1:0]                   redir_tid_o,
  output logic [REDIR_CNT_W-1:0]                   redir_cnt_o
);

  state_t                   state_q;
  state_t                   state_d;
  logic                     grant_en;
  logic                     any_gnt;
  logic                     redir_load;
  logic                     redir_hs;
  logic [NUM_THREADS_P-1:0] gnt;
  logic [TID_WIDTH_P-1:0]   gnt_idx;

  // Reset gates the enable so no thread sees a grant while rst_i is high.
  xrv1_rr_arb #(
    .NUM_REQ_P (NUM_THREADS_P),
    .IDX_W_P   (TID_WIDTH_P)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_vld_i),
    .en_i      (grant_en && !rst_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_rdy_o = gnt;
  assign any_gnt   = |gnt;

  // Next-state, grant window and handshake decode.
  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    redir_load  = 1'b0;
    redir_hs    = 1'b0;
    b_req_o     = 1'b0;
    redir_vld_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_en = 1'b1;
        if (any_gnt) state_d = ISSUE;
      end
      ISSUE: begin
        b_req_o  = 1'b1;
        grant_en = b_rdy_i && !exec_b_pc_vld_i;
        if (b_rdy_i) begin
          if (exec_b_pc_vld_i) begin
            redir_load = 1'b1;
            state_d    = REDIR;
          end else if (any_gnt) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REDIR: begin
        redir_vld_o = 1'b1;
        if (redir_rdy_i) begin
          redir_hs = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue register, redirect capture and saturating redirect counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_is_branch_o <= 1'b0;
      b_is_jump_o   <= 1'b0;
      b_next_pc_o   <= '0;
      b_itag_o      <= '0;
      b_tid_o       <= '0;
      redir_pc_o    <= '0;
      redir_tid_o   <= '0;
      redir_cnt_o   <= '0;
    end else begin
      if (any_gnt) begin
        b_is_branch_o <= req_is_branch_i[gnt_idx];
        b_is_jump_o   <= req_is_jump_i[gnt_idx];
        b_next_pc_o   <= req_next_pc_i[gnt_idx];
        b_itag_o      <= req_itag_i[gnt_idx];
        b_tid_o       <= gnt_idx;
      end
      if (redir_load) begin
        redir_pc_o  <= exec_b_pc_i;
        redir_tid_o <= b_tid_o;
      end
      if (redir_hs) begin
        redir_cnt_o <= sat_inc(redir_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_xrv1_branch_sched.sv
// Self-checking bench for xrv1_branch_sched (4 threads, 6-bit tags).
module tb_xrv1_branch_sched;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       req_vld_i;
  logic [3:0]       req_rdy_o;
  logic [3:0]       req_is_branch_i;
  logic [3:0]       req_is_jump_i;
  logic [3:0][31:0] req_next_pc_i;
  logic [3:0][5:0]  req_itag_i;
  logic             b_req_o;
  logic             b_is_branch_o;
  logic             b_is_jump_o;
  logic [31:0]      b_next_pc_o;
  logic [5:0]       b_itag_o;
  logic [1:0]       b_tid_o;
  logic             b_rdy_i;
  logic             exec_b_pc_vld_i;
  logic [31:0]      exec_b_pc_i;
  logic             redir_vld_o;
  logic             redir_rdy_i;
  logic [31:0]      redir_pc_o;
  logic [1:0]       redir_tid_o;
  logic [15:0]      redir_cnt_o;

  xrv1_branch_sched #(
    .NUM_THREADS_P (4),
    .ITAG_WIDTH_P  (6)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_vld_i       (req_vld_i),
    .req_rdy_o       (req_rdy_o),
    .req_is_branch_i (req_is_branch_i),
    .req_is_jump_i   (req_is_jump_i),
    .req_next_pc_i   (req_next_pc_i),
    .req_itag_i      (req_itag_i),
    .b_req_o         (b_req_o),
    .b_is_branch_o   (b_is_branch_o),
    .b_is_jump_o     (b_is_jump_o),
    .b_next_pc_o     (b_next_pc_o),
    .b_itag_o        (b_itag_o),
    .b_tid_o         (b_tid_o),
    .b_rdy_i         (b_rdy_i),
    .exec_b_pc_vld_i (exec_b_pc_vld_i),
    .exec_b_pc_i     (exec_b_pc_i),
    .redir_vld_o     (redir_vld_o),
    .redir_rdy_i     (redir_rdy_i),
    .redir_pc_o      (redir_pc_o),
    .redir_tid_o     (redir_tid_o),
    .redir_cnt_o     (redir_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] gnt;
  } vec_t;

  vec_t        vecs [14];
  logic [63:0] sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_op(input logic br, input logic jp, input logic [31:0] pc,
                                        input logic [5:0] itag, input logic [1:0] tid);
    return {22'b0, br, jp, pc, itag, tid};
  endfunction

  function automatic logic [31:0] pc_of(input int v, input int t);
    return 32'h1000_0000 + 32'(v * 256 + t * 4);
  endfunction

  function automatic logic [63:0] exp_op(input int v, input int t);
    return mk_op(t[0], t[1], pc_of(v, t), 6'(v * 4 + t), 2'(t));
  endfunction

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic set_data(input int v);
    for (int t = 0; t < 4; t++) begin
      req_is_branch_i[t] = t[0];
      req_is_jump_i[t]   = t[1];
      req_next_pc_i[t]   = pc_of(v, t);
      req_itag_i[t]      = 6'(v * 4 + t);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sb_q.delete();
    next_cycle();
    rst_i = 1'b0;
  endtask

  // Scoreboard: every op accepted by the branch unit must match the oldest expectation.
  always @(negedge clk_i) begin
    if (mon_en && !rst_i && b_req_o && b_rdy_i) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL issue_unexpected: actual tid %0d required no op (t=%0t)", b_tid_o, $time);
      end else begin
        check("issue_op", {22'b0, b_is_branch_o, b_is_jump_o, b_next_pc_o, b_itag_o, b_tid_o},
              sb_q.pop_front());
      end
    end
  end

  int          hs;
  int          cyc;
  int          sat_bad;
  logic        just_hs;
  logic [15:0] exp_cnt;

  initial begin
    // Table: request mask for one grant cycle and the one-hot grant it must produce.
    vecs[0]  = '{4'b0001, 4'b0001};
    vecs[1]  = '{4'b0001, 4'b0001};
    vecs[2]  = '{4'b1111, 4'b0010};
    vecs[3]  = '{4'b1111, 4'b0100};
    vecs[4]  = '{4'b1111, 4'b1000};
    vecs[5]  = '{4'b1111, 4'b0001};
    vecs[6]  = '{4'b0000, 4'b0000};
    vecs[7]  = '{4'b1001, 4'b1000};
    vecs[8]  = '{4'b1010, 4'b0010};
    vecs[9]  = '{4'b0011, 4'b0001};
    vecs[10] = '{4'b1100, 4'b0100};
    vecs[11] = '{4'b0110, 4'b0010};
    vecs[12] = '{4'b0100, 4'b0100};
    vecs[13] = '{4'b1000, 4'b1000};

    rst_i           = 1'b1;
    req_vld_i       = 4'b1111;
    b_rdy_i         = 1'b0;
    exec_b_pc_vld_i = 1'b0;
    exec_b_pc_i     = '0;
    redir_rdy_i     = 1'b0;
    set_data(0);

    #3;
    check("rst_req_rdy",   req_rdy_o,   0);
    check("rst_b_req",     b_req_o,     0);
    check("rst_redir_vld", redir_vld_o, 0);
    check("rst_redir_cnt", redir_cnt_o, 0);
    check("rst_b_data",    {b_next_pc_o, b_itag_o, b_tid_o}, 0);
    check("rst_redir_data", {redir_pc_o, redir_tid_o}, 0);
    next_cycle();
    rst_i     = 1'b0;
    req_vld_i = 4'b0000;

    // Table-driven round-robin with b_rdy_i=1 (back-to-back issue).
    b_rdy_i = 1'b1;
    for (int v = 0; v < 14; v++) begin
      set_data(v);
      req_vld_i = vecs[v].mask;
      @(negedge clk_i);
      check($sformatf("grant_vec%0d", v), req_rdy_o, vecs[v].gnt);
      if (vecs[v].gnt != 4'b0000) sb_q.push_back(exp_op(v, oh_idx(vecs[v].gnt)));
      next_cycle();
    end
    req_vld_i = 4'b0000;
    @(negedge clk_i);
    next_cycle();
    @(negedge clk_i);
    check("table_idle_b_req", b_req_o, 0);
    check("table_sb_drained", sb_q.size(), 0);
    next_cycle();

    // Threads 0 and 2 requesting continuously: 0,2,0,2 one per cycle.
    do_reset();
    set_data(20);
    req_vld_i = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check($sformatf("alt_grant%0d", i), req_rdy_o, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      if (i > 0) check($sformatf("alt_b_req%0d", i), b_req_o, 1);
      sb_q.push_back(exp_op(20, (i % 2 == 0) ? 0 : 2));
      next_cycle();
    end
    req_vld_i = 4'b0000;
    @(negedge clk_i);
    check("alt_last_b_req", b_req_o, 1);
    next_cycle();
    @(negedge clk_i);
    check("alt_idle", b_req_o, 0);
    check("alt_sb_drained", sb_q.size(), 0);
    next_cycle();

    // Single op from thread 1 stalled three cycles by b_rdy_i=0.
    do_reset();
    set_data(30);
    req_next_pc_i[1] = 32'h0000_1004;
    req_vld_i = 4'b0010;
    b_rdy_i   = 1'b0;
    @(negedge clk_i);
    check("stall_grant", req_rdy_o, 4'b0010);
    sb_q.push_back(mk_op(1'b1, 1'b0, 32'h0000_1004, 6'(30 * 4 + 1), 2'd1));
    next_cycle();
    req_vld_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("stall_b_req%0d", i), b_req_o, 1);
      check($sformatf("stall_fields%0d", i), {b_next_pc_o, b_tid_o}, {32'h0000_1004, 2'd1});
      check($sformatf("stall_no_grant%0d", i), req_rdy_o, 0);
      next_cycle();
    end
    req_vld_i = 4'b0000;
    b_rdy_i   = 1'b1;
    @(negedge clk_i);
    check("stall_b_req_accept", b_req_o, 1);
    next_cycle();
    @(negedge clk_i);
    check("stall_idle", b_req_o, 0);
    next_cycle();

    // Redirect on thread 3, fetch back-pressures two cycles.
    do_reset();
    set_data(40);
    req_vld_i   = 4'b1000;
    redir_rdy_i = 1'b0;
    @(negedge clk_i);
    check("redir_grant3", req_rdy_o, 4'b1000);
    sb_q.push_back(exp_op(40, 3));
    next_cycle();
    req_vld_i       = 4'b1111;
    exec_b_pc_vld_i = 1'b1;
    exec_b_pc_i     = 32'h0000_2000;
    @(negedge clk_i);
    check("redir_exec_no_grant", req_rdy_o, 0);
    check("redir_exec_b_req", b_req_o, 1);
    next_cycle();
    exec_b_pc_vld_i = 1'b0;
    exec_b_pc_i     = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) redir_rdy_i = 1'b1;
      @(negedge clk_i);
      check($sformatf("redir_vld%0d", i), redir_vld_o, 1);
      check($sformatf("redir_pc_tid%0d", i), {redir_pc_o, redir_tid_o}, {32'h0000_2000, 2'd3});
      check($sformatf("redir_req_rdy%0d", i), req_rdy_o, 0);
      check($sformatf("redir_cnt_pre%0d", i), redir_cnt_o, 0);
      next_cycle();
    end
    redir_rdy_i = 1'b0;
    @(negedge clk_i);
    check("redir_done_vld", redir_vld_o, 0);
    check("redir_cnt_post", redir_cnt_o, 1);
    check("redir_after_grant", req_rdy_o, 4'b0001);
    sb_q.push_back(exp_op(40, 0));
    next_cycle();
    req_vld_i = 4'b0000;
    @(negedge clk_i);
    next_cycle();

    // Reset while in REDIR, then first grant restarts from pointer 0.
    set_data(50);
    req_vld_i = 4'b0100;
    @(negedge clk_i);
    check("rstredir_grant2", req_rdy_o, 4'b0100);
    sb_q.push_back(exp_op(50, 2));
    next_cycle();
    req_vld_i       = 4'b0000;
    exec_b_pc_vld_i = 1'b1;
    exec_b_pc_i     = 32'h0000_3000;
    @(negedge clk_i);
    next_cycle();
    exec_b_pc_vld_i = 1'b0;
    @(negedge clk_i);
    check("rstredir_in_redir", redir_vld_o, 1);
    #2;
    rst_i     = 1'b1;
    req_vld_i = 4'b1111;
    sb_q.delete();
    #1;
    check("rstredir_vld_drop", redir_vld_o, 0);
    check("rstredir_req_rdy", req_rdy_o, 0);
    check("rstredir_b_req", b_req_o, 0);
    check("rstredir_cnt", redir_cnt_o, 0);
    next_cycle();
    rst_i     = 1'b0;
    req_vld_i = 4'b1010;
    @(negedge clk_i);
    check("rstredir_first_grant", req_rdy_o, 4'b0010);
    sb_q.push_back(exp_op(50, 1));
    next_cycle();
    req_vld_i = 4'b0000;
    @(negedge clk_i);
    next_cycle();

    // Saturation of the redirect counter: 3-cycle grant/issue/redirect loop.
    do_reset();
    mon_en          = 1'b0;
    set_data(60);
    req_vld_i       = 4'b0001;
    b_rdy_i         = 1'b1;
    exec_b_pc_vld_i = 1'b1;
    exec_b_pc_i     = 32'h0000_4000;
    redir_rdy_i     = 1'b1;
    hs      = 0;
    cyc     = 0;
    sat_bad = 0;
    just_hs = 1'b0;
    while (hs < 65540 && cyc < 250000) begin
      @(negedge clk_i);
      cyc++;
      exp_cnt = (hs > 65535) ? 16'hFFFF : 16'(hs);
      if (redir_cnt_o !== exp_cnt) sat_bad++;
      if (just_hs && (hs == 1 || hs == 2 || hs == 100 || hs == 65534 || hs == 65535 ||
                      hs == 65536 || hs == 65539)) begin
        check($sformatf("sat_cnt_after%0d", hs), redir_cnt_o, exp_cnt);
      end
      just_hs = 1'b0;
      if (redir_vld_o && redir_rdy_i) begin
        hs++;
        just_hs = 1'b1;
      end
    end
    check("sat_handshakes_reached", hs, 65540);
    req_vld_i       = 4'b0000;
    exec_b_pc_vld_i = 1'b0;
    @(negedge clk_i);
    check("sat_hold_ffff", redir_cnt_o, 16'hFFFF);
    check("sat_cycle_errors", sat_bad, 0);
    redir_rdy_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
